// File: rtl/fpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_seq_ctrl
//
// Issue/completion sequencer between the EX stage and the pipelined FP units.
// One FP op is accepted at a time. Its latency is counted down. The selected
// unit result is then captured into fpuResult and announced with a one-cycle
// result_valid pulse. While an op is in flight, fpu_inprogress stalls the core.
//
// Optional feature macro: FPU_FFLAGS_EN
//   defined   : sticky exception flags {NV,DZ,OF,UF,NX} are accumulated at
//               every capture and zeroed by fflags_clr.
//   undefined : fflags is tied to 0; the *_exc inputs and fflags_clr are
//               ignored.
//
// Ports
//   clock          in   system clock, rising edge
//   clear          in   asynchronous active-low reset
//   fpu_sel        in   issue request for the op in EX
//   fpuOp          in   op code (0 add,1 sub,2 mul,3 div,4 sgnj,5 min/max,
//                       6 sqrt,7 cmp,8 cvt.w.s,9 cvt.s.w)
//   func3          in   sub-op select
//   flush          in   abort the op in flight
//   dataA, dataB   in   operands, held stable by the core during the stall
//   *_res          in   unit results
//   feq, flt, fle  in   compare unit flags
//   add_exc        in   {nan,ovf,unf}
//   mul_exc        in   {nan,ovf,unf}
//   div_exc        in   {dz,nan,ovf,unf}
//   sqrt_exc       in   {nan,ovf}
//   fflags_clr     in   clear sticky flags
//   fpuResult      out  registered result
//   result_valid   out  one-cycle completion pulse
//   fpu_inprogress out  stall request to the core
//   fflags         out  {NV,DZ,OF,UF,NX}, sticky
// -----------------------------------------------------------------------------
module fpu_seq_ctrl #(
  parameter int WIDTH    = 32,
  parameter int LAT_ADD  = 7,
  parameter int LAT_MUL  = 5,
  parameter int LAT_DIV  = 6,
  parameter int LAT_SQRT = 16,
  parameter int LAT_CMP  = 1,
  parameter int LAT_CVT  = 6,
  parameter int CNT_W    = 5   // every LAT_* must fit in CNT_W bits
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             fpu_sel,
  input  logic [3:0]       fpuOp,
  input  logic [2:0]       func3,
  input  logic             flush,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [WIDTH-1:0] add_res,
  input  logic [WIDTH-1:0] mul_res,
  input  logic [WIDTH-1:0] div_res,
  input  logic [WIDTH-1:0] sqrt_res,
  input  logic [WIDTH-1:0] cvt_ws_res,
  input  logic [WIDTH-1:0] cvt_sw_res,
  input  logic             feq,
  input  logic             flt,
  input  logic             fle,
  input  logic [2:0]       add_exc,
  input  logic [2:0]       mul_exc,
  input  logic [3:0]       div_exc,
  input  logic [1:0]       sqrt_exc,
  input  logic             fflags_clr,
  output logic [WIDTH-1:0] fpuResult,
  output logic             result_valid,
  output logic             fpu_inprogress,
  output logic [4:0]       fflags
);

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DIV    = 4'd3;
  localparam logic [3:0] OP_SGNJ   = 4'd4;
  localparam logic [3:0] OP_MINMAX = 4'd5;
  localparam logic [3:0] OP_SQRT   = 4'd6;
  localparam logic [3:0] OP_CMP    = 4'd7;
  localparam logic [3:0] OP_CVTWS  = 4'd8;
  localparam logic [3:0] OP_CVTSW  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] res_q, res_d;

  logic             capture;
  logic [3:0]       cap_op;
  logic [2:0]       cap_f3;
  logic [CNT_W-1:0] issue_lat;
  logic             inprog;

  // Latency in cycles from the issue cycle to the capture edge. sgnj and
  // unknown op codes complete without waiting.
  function automatic logic [CNT_W-1:0] op_latency(input logic [3:0] op);
    logic [CNT_W-1:0] l;
    l = '0;
    case (op)
      OP_ADD, OP_SUB:     l = CNT_W'(LAT_ADD);
      OP_MUL:             l = CNT_W'(LAT_MUL);
      OP_DIV:             l = CNT_W'(LAT_DIV);
      OP_SQRT:            l = CNT_W'(LAT_SQRT);
      OP_MINMAX, OP_CMP:  l = CNT_W'(LAT_CMP);
      OP_CVTWS, OP_CVTSW: l = CNT_W'(LAT_CVT);
      default:            l = '0;
    endcase
    return l;
  endfunction

  // Value written into fpuResult when an op completes.
  function automatic logic [WIDTH-1:0] select_result(input logic [3:0] op,
                                                     input logic [2:0] f3);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_ADD, OP_SUB: r = add_res;
      OP_MUL:         r = mul_res;
      OP_DIV:         r = div_res;
      OP_SQRT:        r = sqrt_res;
      OP_SGNJ: begin
        case (f3[1:0])
          2'b00:   r = {dataB[WIDTH-1], dataA[WIDTH-2:0]};
          2'b01:   r = {~dataB[WIDTH-1], dataA[WIDTH-2:0]};
          2'b10:   r = {dataA[WIDTH-1] ^ dataB[WIDTH-1], dataA[WIDTH-2:0]};
          default: r = '0;
        endcase
      end
      // min picks A when A<=B; max (func3[0]=1) inverts that choice.
      OP_MINMAX: r = (fle ^ f3[0]) ? dataA : dataB;
      OP_CMP: begin
        case (f3[1:0])
          2'b00:   r = {{(WIDTH-1){1'b0}}, fle};
          2'b01:   r = {{(WIDTH-1){1'b0}}, flt};
          2'b10:   r = {{(WIDTH-1){1'b0}}, feq};
          default: r = '0;
        endcase
      end
      OP_CVTWS: r = cvt_ws_res;
      OP_CVTSW: r = cvt_sw_res;
      default:  r = '0;
    endcase
    return r;
  endfunction

  assign issue_lat = op_latency(fpuOp);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    f3_d    = f3_q;
    res_d   = res_q;
    capture = 1'b0;
    cap_op  = op_q;
    cap_f3  = f3_q;
    inprog  = 1'b0;

    case (state_q)
      IDLE: begin
        // A simultaneous flush suppresses the issue entirely.
        if (fpu_sel && !flush) begin
          inprog = 1'b1;
          op_d   = fpuOp;
          f3_d   = func3;
          if (issue_lat == '0) begin
            // Zero-latency ops capture at the end of the issue cycle, using
            // the live op code because op_q is not loaded yet.
            capture = 1'b1;
            cap_op  = fpuOp;
            cap_f3  = func3;
            state_d = DONE;
          end else begin
            // The counter holds the remaining WAIT cycles after the current
            // one; capture happens in the WAIT cycle where it reads zero.
            cnt_d   = issue_lat - CNT_W'(1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        inprog = 1'b1;
        if (flush) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // fpu_sel may still be high for the instruction just completed, so it
        // is deliberately not looked at here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      res_d = select_result(cap_op, cap_f3);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      f3_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
      res_q   <= res_d;
    end
  end

  assign fpuResult      = res_q;
  assign result_valid   = (state_q == DONE);
  // The stall is combinational from fpu_sel so the core holds in the issue
  // cycle itself; it is forced low while reset is asserted.
  assign fpu_inprogress = inprog & clear;

`ifdef FPU_FFLAGS_EN
  logic [4:0] fflags_q, fflags_d;
  logic       unused_bits;

  // Map the completing unit's exception bits onto {NV,DZ,OF,UF,NX}.
  function automatic logic [4:0] unit_flags(input logic [3:0] op);
    logic [4:0] f;
    f = '0;
    case (op)
      OP_ADD, OP_SUB: f = {add_exc[2], 1'b0, add_exc[1], add_exc[0], 1'b0};
      OP_MUL:         f = {mul_exc[2], 1'b0, mul_exc[1], mul_exc[0], 1'b0};
      OP_DIV:         f = {div_exc[2], div_exc[3], div_exc[1], div_exc[0], 1'b0};
      OP_SQRT:        f = {sqrt_exc[1], 1'b0, sqrt_exc[0], 1'b0, 1'b0};
      default:        f = '0;
    endcase
    return f;
  endfunction

  // Clear first, then OR in the capture, so a same-cycle capture keeps its bits.
  always_comb begin
    fflags_d = fflags_clr ? 5'b0 : fflags_q;
    if (capture) begin
      fflags_d = fflags_d | unit_flags(cap_op);
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      fflags_q <= '0;
    end else begin
      fflags_q <= fflags_d;
    end
  end

  assign fflags      = fflags_q;
  assign unused_bits = func3[2];
`else
  logic unused_bits;

  assign fflags      = 5'b0;
  assign unused_bits = ^{func3[2], add_exc, mul_exc, div_exc, sqrt_exc,
                         fflags_clr};
`endif

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
Parametrised issue/completion sequencer that sits between the EX stage and the pipelined FP units (add/sub, mult, div, sqrt, compare, convert).
- Accepts one FP op at a time and counts the per-op latency.
- Captures the selected unit result into a register and drives the core stall (fpu_inprogress) and a one-cycle result_valid.
- Adds flush, parametrised latencies and optional sticky exception flags.

Parameters:
- WIDTH, 32, data width.
- LAT_ADD, 7, add/sub unit latency (cycles).
- LAT_MUL, 5, multiplier latency.
- LAT_DIV, 6, divider latency.
- LAT_SQRT, 16, sqrt latency.
- LAT_CMP, 1, compare latency (also used for min/max).
- LAT_CVT, 6, both convert latencies.
- CNT_W, 5, counter width; every LAT_* must be ≤ 2^CNT_W-1.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- fpu_sel  in  1  issue request for the op in EX.
- fpuOp  in  4  op code: 0 add, 1 sub, 2 mul, 3 div, 4 sgnj, 5 min/max, 6 sqrt, 7 cmp, 8 cvt.w.s, 9 cvt.s.w.
- func3  in  3  sub-op select.
- flush  in  1  abort the op in flight.
- dataA, dataB  in  WIDTH  operands; held stable by the core while fpu_inprogress=1.
- add_res, mul_res, div_res, sqrt_res, cvt_ws_res, cvt_sw_res  in  WIDTH  unit outputs.
- feq, flt, fle  in  1  compare unit flags.
- add_exc, mul_exc  in  3  {nan,ovf,unf}.
- div_exc  in  4  {dz,nan,ovf,unf}.
- sqrt_exc  in  2  {nan,ovf}.
- fflags_clr  in  1  clear sticky flags.
- fpuResult  out  WIDTH  registered result.
- result_valid  out  1  one-cycle completion pulse.
- fpu_inprogress  out  1  stall request to the core.
- fflags  out  5  {NV,DZ,OF,UF,NX}, sticky.

Behaviour:
- Reset (clear=0, async): state=IDLE, counter=0, fpuResult=0, result_valid=0, fflags=0. fpu_inprogress=0 while clear is low.
- States: IDLE, WAIT, DONE.
- Issue: fpu_sel=1 in IDLE in cycle N. Latch fpuOp/func3 and select latency L:
  - add/sub = LAT_ADD; mul = LAT_MUL; div = LAT_DIV; sqrt = LAT_SQRT; cmp and min/max = LAT_CMP; cvt = LAT_CVT.
  - sgnj and unsupported op codes (≥10) = 0.
- Timing for an issue in cycle N:
  - Result captured at the clock edge ending cycle N+L; state=DONE in cycle N+L+1.
  - result_valid=1 only in DONE.
  - fpu_inprogress=1 combinationally in cycles N..N+L (issue cycle included), 0 in DONE.
  - L=0: IDLE→DONE directly.
  - DONE→IDLE unconditionally.
- fpu_sel is ignored in WAIT and DONE. It may still be high in DONE for the same instruction, so there is no reissue.
- Result select at capture:
  - sgnj: func3[1:0]=00 {B31,A[30:0]}, 01 {~B31,A[30:0]}, 10 {A31^B31,A[30:0]}, 11 → 0.
  - min/max: func3[0]=0 → fle?A:B; func3[0]=1 → fle?B:A.
  - cmp: func3[1:0]=00 fle, 01 flt, 10 feq, zero-extended to WIDTH; 11 → 0.
  - cvt.w.s → cvt_ws_res; cvt.s.w → cvt_sw_res; unsupported → 0.
- fpuResult holds its value until the next capture. flush and the IDLE state do not change it.
- flush=1 in WAIT: return to IDLE next cycle, no capture, no result_valid. fpu_inprogress drops in the cycle after flush.
- flush in IDLE or DONE: no effect. A DONE pulse still completes.
- flush together with fpu_sel in IDLE: flush wins, no issue.

Optional Feature:
FPU_FFLAGS_EN
- Defined: at capture, fflags is ORed with the mapped unit flags:
  - NV ← nan of add/mul/div/sqrt.
  - DZ ← div dz.
  - OF ← ovf.
  - UF ← unf.
  - NX always 0.
- Flags are sticky. fflags_clr zeroes them next cycle; a capture in the same cycle as fflags_clr wins for its bits.
- Undefined: ports remain, fflags tied to 0, *_exc and fflags_clr ignored.

Test Plan:
- Reset mid-WAIT (sqrt issued cycle 0, clear low at cycle 5) → all outputs 0 immediately. No result_valid afterwards.
- FADD issued cycle 0, add_res=0x40400000 → fpu_inprogress 1 in cycles 0–7, result_valid only in cycle 8, fpuResult=0x40400000.
- FSGNJN A=0x3F800000, B=0x00000000 → result_valid in cycle 1, fpuResult=0xBF800000, fpu_inprogress high only in cycle 0.
- FDIV issued, flush in cycle 3 → no result_valid, fpuResult unchanged, IDLE by cycle 4. Next FMUL issued cycle 5 → valid in cycle 11.
- FLT with flt=1, fle=1, feq=0 → fpuResult=0x00000001 in cycle 2. Same setup with func3=10 → 0x00000000.
- With FPU_FFLAGS_EN: div with div_exc=1000 → fflags=01000. Then add with nan → 11000. fflags_clr → 00000.
